// File: rtl/gshare_predictor_if.sv
// Fetch-lookup and EX-resolution signals of the gshare branch predictor.
// master = pipeline side, slave = predictor side.
interface gshare_predictor_if #(
  parameter int unsigned GHSR_W = 10
);
  logic [31:0]       if_pc;
  logic              if_fire;
  logic              pred_taken;
  logic [GHSR_W-1:0] pred_ghsr;
  logic              btb_hit;
  logic [31:0]       btb_addr;

  logic              ex_valid;
  logic              ex_is_branch;
  logic              ex_is_jump;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_target;
  logic              ex_taken;
  logic [GHSR_W-1:0] ex_ghsr;
  logic              ex_mispredict;

  modport master (
    output if_pc, if_fire,
    output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target,
    output ex_taken, ex_ghsr, ex_mispredict,
    input  pred_taken, pred_ghsr, btb_hit, btb_addr
  );

  modport slave (
    input  if_pc, if_fire,
    input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target,
    input  ex_taken, ex_ghsr, ex_mispredict,
    output pred_taken, pred_ghsr, btb_hit, btb_addr
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (2-bit PHT) with a direct-mapped BTB; combinational lookup.
// Optional speculative history update at fetch: define GSHARE_SPEC_GHSR_EN.
module gshare_predictor #(
  parameter int unsigned GHSR_W      = 10,
  parameter int unsigned PHT_SIZE    = 1024,
  parameter int unsigned BTB_ENTRIES = 512
) (
  input  logic           clk,
  input  logic           reset_n,
  gshare_predictor_if.slave bp
);

  localparam int unsigned PHT_IW = $clog2(PHT_SIZE);
  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = 30 - BTB_IW;

  logic [GHSR_W-1:0] ghsr;
  logic [1:0]        pht        [PHT_SIZE];
  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [31:0]       btb_target [BTB_ENTRIES];
  logic              btb_jump   [BTB_ENTRIES];

  function automatic logic [PHT_IW-1:0] pht_index(input logic [GHSR_W-1:0] h,
                                                  input logic [31:0]       pc);
    return PHT_IW'(h) ^ pc[PHT_IW+1:2];
  endfunction

  // Fetch-side lookup
  logic [BTB_IW-1:0] f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [1:0]        f_ctr;
  logic              f_hit;
  logic              f_jump;
  logic              f_taken;

  assign f_idx   = bp.if_pc[BTB_IW+1:2];
  assign f_tag   = bp.if_pc[31:BTB_IW+2];
  assign f_ctr   = pht[pht_index(ghsr, bp.if_pc)];
  assign f_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_jump  = btb_jump[f_idx];
  assign f_taken = f_hit && (f_jump || f_ctr[1]);

  assign bp.btb_hit    = f_hit;
  assign bp.pred_taken = f_taken;
  assign bp.btb_addr   = f_hit ? btb_target[f_idx] : '0;
  assign bp.pred_ghsr  = ghsr;

  // Resolution-side update
  logic              ex_br;
  logic              btb_we;
  logic [PHT_IW-1:0] u_idx;
  logic [1:0]        u_ctr;
  logic [1:0]        u_next;
  logic [BTB_IW-1:0] w_idx;

  assign ex_br  = bp.ex_valid && bp.ex_is_branch;
  // Jumps count as taken regardless of ex_taken
  assign btb_we = bp.ex_valid && (bp.ex_is_jump || (bp.ex_is_branch && bp.ex_taken));
  assign u_idx  = pht_index(bp.ex_ghsr, bp.ex_pc);
  assign u_ctr  = pht[u_idx];
  assign w_idx  = bp.ex_pc[BTB_IW+1:2];

  always_comb begin
    u_next = u_ctr;
    if (bp.ex_taken) begin
      if (u_ctr != 2'b11) u_next = u_ctr + 2'b01;
    end else begin
      if (u_ctr != 2'b00) u_next = u_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b01;
    end else if (ex_br) begin
      pht[u_idx] <= u_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid[w_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: an entry is only visible once its valid bit is set
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[w_idx]    <= bp.ex_pc[31:BTB_IW+2];
      btb_target[w_idx] <= bp.ex_target;
      btb_jump[w_idx]   <= bp.ex_is_jump;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghsr <= '0;
`ifdef GSHARE_SPEC_GHSR_EN
    end else if (ex_br && bp.ex_mispredict) begin
      ghsr <= {bp.ex_ghsr[GHSR_W-2:0], bp.ex_taken};
    end else if (bp.ex_valid && bp.ex_is_jump && bp.ex_mispredict) begin
      ghsr <= bp.ex_ghsr;
    end else if (bp.if_fire && f_hit && !f_jump) begin
      ghsr <= {ghsr[GHSR_W-2:0], f_taken};
    end
`else
    end else if (ex_br) begin
      ghsr <= {ghsr[GHSR_W-2:0], bp.ex_taken};
    end
`endif
  end

  logic unused_ok;
`ifdef GSHARE_SPEC_GHSR_EN
  assign unused_ok = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};
`else
  assign unused_ok = ^{bp.if_pc[1:0], bp.ex_pc[1:0], bp.if_fire, bp.ex_mispredict};
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized bench for gshare_predictor against a table-level reference model,
// plus hand-computed directed scenarios.
module tb_gshare_predictor;

  localparam int unsigned GW   = 10;
  localparam int unsigned MASK = 1023;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_if #(.GHSR_W(GW)) bp ();

  gshare_predictor #(.GHSR_W(GW), .PHT_SIZE(1024), .BTB_ENTRIES(512)) dut (
    .clk(clk), .reset_n(reset_n), .bp(bp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_pht [1024];
  bit          m_valid [512];
  int unsigned m_tag [512];
  int unsigned m_tgt [512];
  bit          m_jmp [512];
  int unsigned m_ghsr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 512; i++) m_valid[i] = 0;
    m_ghsr = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit hit, output bit taken,
                              output int unsigned addr, output bit jmp);
    int unsigned bi, pi;
    bi    = (pc >> 2) % 512;
    pi    = (m_ghsr ^ (pc >> 2)) % 1024;
    hit   = m_valid[bi] && (m_tag[bi] == (pc >> 11));
    jmp   = m_jmp[bi];
    taken = hit && (jmp || m_pht[pi] >= 2);
    addr  = hit ? m_tgt[bi] : 0;
  endtask

  task automatic model_update();
    bit h, t, j;
    int unsigned a, pi, bi;
    if (!reset_n) return;
    model_lookup(bp.if_pc, h, t, a, j);
`ifdef GSHARE_SPEC_GHSR_EN
    if (bp.ex_valid && bp.ex_is_branch && bp.ex_mispredict)
      m_ghsr = ((int'(bp.ex_ghsr) << 1) | int'(bp.ex_taken)) & MASK;
    else if (bp.ex_valid && bp.ex_is_jump && bp.ex_mispredict)
      m_ghsr = bp.ex_ghsr;
    else if (bp.if_fire && h && !j)
      m_ghsr = ((m_ghsr << 1) | int'(t)) & MASK;
`else
    if (bp.ex_valid && bp.ex_is_branch)
      m_ghsr = ((m_ghsr << 1) | int'(bp.ex_taken)) & MASK;
`endif
    if (bp.ex_valid && bp.ex_is_branch) begin
      pi = (bp.ex_ghsr ^ (bp.ex_pc >> 2)) % 1024;
      if (bp.ex_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
      else             m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
    end
    if (bp.ex_valid && (bp.ex_is_jump || (bp.ex_is_branch && bp.ex_taken))) begin
      bi = (bp.ex_pc >> 2) % 512;
      m_valid[bi] = 1;
      m_tag[bi]   = bp.ex_pc >> 11;
      m_tgt[bi]   = bp.ex_target;
      m_jmp[bi]   = bp.ex_is_jump;
    end
  endtask

  task automatic check_model();
    bit h, t, j;
    int unsigned a;
    model_lookup(bp.if_pc, h, t, a, j);
    chk("btb_hit", 32'(bp.btb_hit), 32'(h));
    chk("pred_taken", 32'(bp.pred_taken), 32'(t));
    chk("btb_addr", bp.btb_addr, a);
    chk("pred_ghsr", 32'(bp.pred_ghsr), m_ghsr);
  endtask

  // One clock: check outputs, let the edge happen, mirror it, return at negedge
  task automatic cyc();
    #1 check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bp.if_fire = 0; bp.ex_valid = 0; bp.ex_is_branch = 0; bp.ex_is_jump = 0;
    bp.ex_taken = 0; bp.ex_mispredict = 0; bp.ex_pc = 0; bp.ex_target = 0; bp.ex_ghsr = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input bit br,
                         input bit jmp, input bit taken, input logic [GW-1:0] gh);
    bp.ex_valid = 1; bp.ex_is_branch = br; bp.ex_is_jump = jmp; bp.ex_pc = pc;
    bp.ex_target = tgt; bp.ex_taken = taken; bp.ex_ghsr = gh; bp.ex_mispredict = 0;
    cyc();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) cyc();
    reset_n = 1;
  endtask

  // Ten not-taken branches at 0xFFC shift the history back to zero without
  // touching the counter index used by PC 0x100.
  task automatic flush_history();
    for (int i = 0; i < 10; i++) resolve(32'hFFC, 32'h0, 1, 0, 0, GW'(m_ghsr));
  endtask

  task automatic lookup_lit(input string name, input logic [31:0] pc, input bit ehit,
                            input bit etaken, input logic [31:0] eaddr);
    idle_inputs();
    bp.if_pc = pc;
    #1;
    chk({name, ".hit"},   32'(bp.btb_hit),    32'(ehit));
    chk({name, ".taken"}, 32'(bp.pred_taken), 32'(etaken));
    chk({name, ".addr"},  bp.btb_addr,        eaddr);
    cyc();
  endtask

  int unsigned pool [8] = '{32'h100, 32'h900, 32'h104, 32'h2100,
                            32'h40, 32'h840, 32'hFFC, 32'h3000};

  initial begin
    idle_inputs();
    bp.if_pc = 32'h100;
    model_reset();
    #1;
    chk("reset.hit",   32'(bp.btb_hit),    0);
    chk("reset.taken", 32'(bp.pred_taken), 0);
    chk("reset.addr",  bp.btb_addr,        0);
    chk("reset.ghsr",  32'(bp.pred_ghsr),  0);
    @(negedge clk);
    do_reset();

`ifndef GSHARE_SPEC_GHSR_EN
    // Taken branch trains BTB and counter 01->10
    lookup_lit("post_reset", 32'h100, 0, 0, 0);
    resolve(32'h100, 32'h80, 1, 0, 1, '0);
    #1 chk("ghsr_after_taken", 32'(bp.pred_ghsr), 1);
    flush_history();
    #1 chk("ghsr_flushed", 32'(bp.pred_ghsr), 0);
    lookup_lit("trained", 32'h100, 1, 1, 32'h80);

    // Counter walk 01,00,00,00,00,01,10
    do_reset();
    for (int i = 0; i < 4; i++) resolve(32'h100, 32'h80, 1, 0, 0, '0);
    lookup_lit("after_4nt", 32'h100, 0, 0, 0);
    resolve(32'h100, 32'h80, 1, 0, 1, '0);
    flush_history();
    lookup_lit("after_1t", 32'h100, 1, 0, 32'h80);
    resolve(32'h100, 32'h80, 1, 0, 1, '0);
    flush_history();
    lookup_lit("after_2t", 32'h100, 1, 1, 32'h80);

    // Aliasing JAL at 0x900 evicts the 0x100 branch entry
    do_reset();
    resolve(32'h100, 32'h80, 1, 0, 1, '0);
    resolve(32'h900, 32'h1234, 0, 1, 0, '0);
    lookup_lit("alias_evicted", 32'h100, 0, 0, 0);
    lookup_lit("alias_jump", 32'h900, 1, 1, 32'h1234);
    #1 chk("jump_no_shift", 32'(bp.pred_ghsr), 1);
`endif

    // Asynchronous reset in the middle of a cycle with an update pending
    do_reset();
    resolve(32'h900, 32'h1234, 0, 1, 1, '0);
    bp.if_pc = 32'h900;
    bp.ex_valid = 1; bp.ex_is_branch = 1; bp.ex_pc = 32'h100;
    bp.ex_target = 32'h80; bp.ex_taken = 1;
    #1 check_model();
    @(posedge clk);
    model_update();
    #3 reset_n = 0;
    #1;
    chk("async.hit",   32'(bp.btb_hit),    0);
    chk("async.taken", 32'(bp.pred_taken), 0);
    chk("async.addr",  bp.btb_addr,        0);
    chk("async.ghsr",  32'(bp.pred_ghsr),  0);
    model_reset();
    @(negedge clk);
    cyc();
    reset_n = 1;
    lookup_lit("async_release_900", 32'h900, 0, 0, 0);
    lookup_lit("async_release_100", 32'h100, 0, 0, 0);

    // Randomized traffic over a small, aliasing PC pool
    for (int n = 0; n < 3000; n++) begin
      bp.if_pc         = pool[$urandom_range(0, 7)];
      bp.if_fire       = 1'($urandom_range(0, 1));
      bp.ex_valid      = ($urandom_range(0, 3) != 0);
      bp.ex_is_jump    = ($urandom_range(0, 9) < 3);
      bp.ex_is_branch  = !bp.ex_is_jump;
      bp.ex_pc         = pool[$urandom_range(0, 7)];
      bp.ex_target     = $urandom & 32'hFFFF_FFFC;
      bp.ex_taken      = 1'($urandom_range(0, 1));
      bp.ex_ghsr       = ($urandom_range(0, 1) != 0) ? GW'(m_ghsr) : GW'($urandom_range(0, 3));
      bp.ex_mispredict = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameters SHALL be: GHSR_W default 10, global history width; PHT_SIZE default 1024, 2-bit counter entries; BTB_ENTRIES default 512, target-buffer entries.
REQ-002 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 if_pc  in  32  fetch PC being looked up.
REQ-005 if_fire  in  1  fetch advances this cycle (valid and not stalled).
REQ-006 pred_taken  out  1  predicted taken.
REQ-007 pred_ghsr  out  GHSR_W  GHSR value used for this lookup; it travels down the pipe with the instruction.
REQ-008 btb_hit  out  1  BTB tag match for if_pc.
REQ-009 btb_addr  out  32  predicted target; 0 when btb_hit=0.
REQ-010 ex_valid  in  1  resolved control-flow instruction in EX.
REQ-011 ex_is_branch, ex_is_jump  in  1 each  conditional branch or JAL/JALR.
REQ-012 ex_pc, ex_target  in  32 each  resolved instruction PC and target.
REQ-013 ex_taken  in  1  actual outcome; jumps SHALL always be treated as taken.
REQ-014 ex_ghsr  in  GHSR_W  pred_ghsr carried with the resolved instruction.
REQ-015 ex_mispredict  in  1  direction or target mispredicted; the pipe flushes this cycle.

Function
REQ-016 PHT index SHALL be ghsr XOR pc[11:2], 10 bits, with the low two PC bits dropped.
REQ-017 BTB index SHALL be pc[10:2]; tag SHALL be pc[31:11]; each entry SHALL hold valid, tag[20:0], target[31:0] and is_jump.
REQ-018 Lookup SHALL be combinational, with zero-cycle latency from if_pc to all pred_* outputs.
REQ-019 btb_hit SHALL be valid AND tag match.
REQ-020 pred_taken SHALL be btb_hit AND (entry is_jump OR PHT counter bit[1]).
REQ-021 PHT counters SHALL saturate: on ex_valid&ex_is_branch, counter[hash(ex_ghsr,ex_pc)] increments when ex_taken (holds at 2'b11) and decrements otherwise (holds at 2'b00).
REQ-022 Jumps SHALL NOT update the PHT.
REQ-023 On ex_valid&ex_taken&(ex_is_branch|ex_is_jump), the BTB entry at idx(ex_pc) SHALL be written with valid=1, tag(ex_pc), ex_target and is_jump=ex_is_jump; it overwrites any existing entry (direct-mapped).
REQ-024 Not-taken branches SHALL NOT modify the BTB.
REQ-025 A same-cycle lookup and update to the same PHT or BTB entry SHALL return the pre-update value; there is no bypass.
REQ-026 pred_ghsr SHALL equal the current GHSR register value.

Reset
REQ-027 While reset_n=0: GHSR SHALL be 0, every PHT counter 2'b01 (weakly not-taken), and every BTB valid bit 0; tag and target contents are don't-care.
REQ-028 Reset asserted mid-update SHALL discard that update.
REQ-029 Outputs during reset SHALL be pred_taken=0, btb_hit=0, btb_addr=0 and pred_ghsr=0.

Configuration
REQ-030 With GSHARE_SPEC_GHSR_EN defined, on if_fire&btb_hit&!is_jump the GHSR SHALL become {GHSR[GHSR_W-2:0], pred_taken}.
REQ-031 With GSHARE_SPEC_GHSR_EN defined, on ex_valid&ex_is_branch&ex_mispredict the GHSR SHALL become {ex_ghsr[GHSR_W-2:0], ex_taken}, taking priority over a same-cycle speculative shift.
REQ-032 With GSHARE_SPEC_GHSR_EN defined, a jump mispredict SHALL restore GHSR to ex_ghsr.
REQ-033 Without GSHARE_SPEC_GHSR_EN, the GHSR SHALL shift only at resolution: on ex_valid&ex_is_branch it becomes {GHSR[GHSR_W-2:0], ex_taken}, and if_fire has no effect on the GHSR.

Verification
REQ-034 Reset, then if_pc=0x100 -> btb_hit=0, pred_taken=0, btb_addr=0, pred_ghsr=0.
REQ-035 Taken branch resolve ex_pc=0x100, ex_target=0x80, ex_ghsr=0, then lookup 0x100 -> btb_hit=1, btb_addr=0x80, and counter 01->10 gives pred_taken=1 (without spec GHSR).
REQ-036 Four not-taken resolves at the same ex_pc/ex_ghsr, then two taken -> counter 01,00,00,00,00,01,10; pred_taken=1 only after the second taken.
REQ-037 Aliasing: branch at 0x100 resolved taken, then JAL at 0x100+0x800 (same index, different tag) -> lookup 0x100 gives btb_hit=0; the jump entry gives pred_taken=1 regardless of counter.
REQ-038 GSHARE_SPEC_GHSR_EN: three fetch hits predicted 1,1,0 give GHSR=0b110; a mispredict with ex_ghsr=0b1, ex_taken=0 in the same cycle as a fetch hit gives GHSR=0b10.
REQ-039 Assert reset_n=0 asynchronously mid-cycle during ex_valid -> outputs zero immediately, all counters read 01 after release, no BTB hits.
